// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit carry-select slice, one nibble per clock, LSB first.
// Define NIBBLE_ADDER_SUB_EN to add a 'sub' input that turns the operation into a - b.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4, >= 4");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [IW-1:0]    idx;
  logic             carry_q;
  logic             cout_q;
  logic             valid_q;

  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [4:0]       r0;
  logic [4:0]       r1;
  logic [4:0]       sel;
  logic [WIDTH-1:0] sum_next;

`ifdef NIBBLE_ADDER_SUB_EN
  // Two's complement subtract: invert B, force the initial carry to 1.
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  function automatic logic [4:0] ripple(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       c
  );
    logic [4:0] r;
    logic       k;
    k = c;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i] = x[i] ^ y[i] ^ k;
      k    = (x[i] & y[i]) | (k & (x[i] ^ y[i]));
    end
    r[4] = k;
    return r;
  endfunction

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  // Both chains run every cycle; the stored carry only picks one.
  assign r0  = ripple(nib_a, nib_b, 1'b0);
  assign r1  = ripple(nib_a, nib_b, 1'b1);
  assign sel = carry_q ? r1 : r0;

  always_comb begin
    sum_next = sum_q;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        sum_next[4*i +: 4] = sel[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_in;
            carry_q <= c_in;
            idx     <= '0;
            sum_q   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_next;
          carry_q <= sel[4];
          idx     <= idx + 1'b1;
          if (idx == LAST) begin
            cout_q  <= sel[4];
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16 main instance, WIDTH=4 corner instance).
// Subtract vectors are exercised when NIBBLE_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;

  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        cin4 = 1'b0;
  logic        out_valid4;
  logic        out_ready4 = 1'b0;
  logic [3:0]  sum4;
  logic        cout4;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef NIBBLE_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4),
`ifdef NIBBLE_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4)
  );

  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic c, output bit ok);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    ok = in_ready;
    a = x; b = y; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({in_ready, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      failed++;
      $display("FAIL reset got rdy=%b vld=%b cout=%b sum=%h exp 1 0 0 0000",
               in_ready, out_valid, cout, sum);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    send(16'h1234, 16'h4321, 1'b0, ok);
    wait_out(lat);
    tests++;
    if (!ok || lat !== 4) begin
      failed++;
      $display("FAIL basic_latency got %0d exp 4 (accept=%0b)", lat, ok);
    end
    tests++;
    if ({cout, sum} !== {1'b0, 16'h5555}) begin
      failed++;
      $display("FAIL basic_sum got %b_%h exp 0_5555", cout, sum);
    end
    drain();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL basic_drain got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ripple();
    logic [15:0] va [2] = '{16'hFFFF, 16'hFFFF};
    logic [15:0] vb [2] = '{16'h0001, 16'h0000};
    logic        vc [2] = '{1'b0, 1'b1};
    bit ok;
    int lat;
    for (int i = 0; i < 2; i++) begin
      send(va[i], vb[i], vc[i], ok);
      wait_out(lat);
      tests++;
      if (!out_valid || {cout, sum} !== {1'b1, 16'h0000}) begin
        failed++;
        $display("FAIL ripple%0d got vld=%b %b_%h exp 1_0000", i, out_valid, cout, sum);
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    int bad = 0;
    send(16'h00F0, 16'h0F10, 1'b0, ok);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || in_ready || {cout, sum} !== {1'b0, 16'h1000}) bad++;
      a = a - 16'd3; b = b + 16'd5;
      @(posedge clk); #1;
    end
    tests++;
    if (bad != 0) begin
      failed++;
      $display("FAIL backpressure_hold got %0d unstable cycles exp 0 (last %b_%h)",
               bad, cout, sum);
    end
    in_valid = 1'b0;
    drain();
    tests++;
    if (out_valid !== 1'b0) begin
      failed++;
      $display("FAIL backpressure_drain got vld=%b exp 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int lat;
    int bad = 0;
    send(16'hABCD, 16'h1111, 1'b0, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    tests++;
    if ({in_ready, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      failed++;
      $display("FAIL midrun_reset got rdy=%b vld=%b cout=%b sum=%h exp 1 0 0 0000",
               in_ready, out_valid, cout, sum);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) bad++;
    end
    tests++;
    if (bad != 0) begin
      failed++;
      $display("FAIL midrun_no_valid got %0d valid cycles exp 0", bad);
    end
    send(16'h0001, 16'h0001, 1'b0, ok);
    wait_out(lat);
    tests++;
    if (!out_valid || {cout, sum} !== {1'b0, 16'h0002}) begin
      failed++;
      $display("FAIL midrun_next got vld=%b %b_%h exp 0_0002", out_valid, cout, sum);
    end
    drain();
  endtask

  task automatic test_in_valid_held();
    int seen = 0;
    int bad = 0;
    a = 16'h0001; b = 16'h0002; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        seen++;
        if ({cout, sum} !== {1'b0, 16'h0003}) bad++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tests++;
    if (seen != 10 || bad != 0) begin
      failed++;
      $display("FAIL held_valid got %0d results (%0d wrong) exp 10 (0)", seen, bad);
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_width4();
    logic [3:0] xa [2] = '{4'hF, 4'h3};
    logic [3:0] xb [2] = '{4'h1, 4'h4};
    logic       xc [2] = '{1'b0, 1'b1};
    logic [4:0] ex [2] = '{5'h10, 5'h08};
    for (int i = 0; i < 2; i++) begin
      a4 = xa[i]; b4 = xb[i]; cin4 = xc[i]; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (!out_valid4 || {cout4, sum4} !== ex[i]) begin
        failed++;
        $display("FAIL width4_%0d got vld=%b %b_%h exp 1 %h", i, out_valid4,
                 cout4, sum4, ex[i]);
      end
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
    end
  endtask

`ifdef NIBBLE_ADDER_SUB_EN
  task automatic test_sub();
    bit ok;
    int lat;
    sub = 1'b1;
    send(16'h0005, 16'h0007, 1'b0, ok);
    sub = 1'b0;
    wait_out(lat);
    tests++;
    if (!out_valid || {cout, sum} !== {1'b0, 16'hFFFE}) begin
      failed++;
      $display("FAIL sub_borrow got %b_%h exp 0_fffe", cout, sum);
    end
    drain();
    sub = 1'b1;
    send(16'h0007, 16'h0005, 1'b0, ok);
    sub = 1'b0;
    wait_out(lat);
    tests++;
    if (!out_valid || {cout, sum} !== {1'b1, 16'h0002}) begin
      failed++;
      $display("FAIL sub_noborrow got %b_%h exp 1_0002", cout, sum);
    end
    drain();
  endtask
`endif

  task automatic test_random();
    bit ok;
    int lat;
    int bad = 0;
    int shown = 0;
    logic [15:0] x, y;
    logic        c;
    logic [16:0] exp;
    for (int n = 0; n < 1000; n++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      c = 1'($urandom);
      exp = {1'b0, x} + {1'b0, y} + {16'h0, c};
      send(x, y, c, ok);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      wait_out(lat);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        if (!out_valid || {cout, sum} !== exp) bad++;
      end
      if (!ok || !out_valid || {cout, sum} !== exp) begin
        bad++;
        if (shown < 5) begin
          shown++;
          $display("FAIL random%0d got %b_%h exp %b_%h", n, cout, sum, exp[16], exp[15:0]);
        end
      end
      drain();
      if (out_valid) bad++;
    end
    tests++;
    if (bad != 0) begin
      failed++;
      $display("FAIL random got %0d bad checks exp 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_backpressure();
    test_reset_mid_run();
    test_in_valid_held();
    test_width4();
`ifdef NIBBLE_ADDER_SUB_EN
    test_sub();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
